detector_borda_multi: RTL and testbench
=======================================

Name: detector_borda_multi

Overview:
Parametrised multi-channel edge detector; next generation of the 2-bit rising-edge detector.
- Each channel: input synchroniser, per-channel edge mode (rise, fall, both, off), 1-cycle pulse output, sticky pending flag with clear, saturating event counter.
- Sits between asynchronous board inputs (buttons, sensors) and the control logic.
- A single interrupt line summarises all pending channels.

Parameters:
N_CH, 2, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (0 = bypass, input treated as already synchronous)
CNT_W, 8, width of each per-channel event counter (>=1)
DEB_CYCLES, 4, debounce stability window in cycles (>=1; used only with DETECTOR_DEBOUNCE_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
entrada  input  N_CH  raw input levels, channel i on bit i
modo  input  2*N_CH  edge mode, channel i on bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
limpa  input  N_CH  clear request per channel (level, sampled each clk)
detector  output  N_CH  1-cycle edge pulse per channel (registered)
pendente  output  N_CH  sticky flag per channel, set by pulse, cleared by limpa
contagem  output  N_CH*CNT_W  event counter per channel, channel i on bits [(i+1)*CNT_W-1 : i*CNT_W]
irq  output  1  registered OR of pendente

Behaviour:
- Reset (rst=0, asynchronous): sync chain, previous-level register, detector, pendente, contagem, irq and debounce state all go to 0.
- Sync: entrada[i] passes through SYNC_STAGES flops; output s[i].
- Edge compute, per channel, each clk: rise = s & ~prev; fall = ~s & prev; prev <= s.
- Pulse selection: detector[i] <= (modo01 & rise) | (modo10 & fall) | (modo11 & (rise|fall)). Mode 00 gives 0.
- Latency: SYNC_STAGES+1 clk edges from the first edge that samples the new entrada to the cycle detector is high. With SYNC_STAGES=0 the latency is 1.
- Pulse width is exactly 1 cycle per detected edge. Back-to-back toggles each cycle produce back-to-back pulses in mode 11.
- prev resets to 0: an input held high through reset yields one rise event SYNC_STAGES+1 cycles after reset release.
- Mode change:
  - Takes effect on the next edge computation.
  - Never generates a pulse by itself.
  - prev tracks s in all modes, including 00.
- Pending flag:
  - pendente[i] <= detector[i] ? 1 : (limpa[i] ? 0 : pendente[i]).
  - The flag sets the cycle after the pulse.
  - If set and clear coincide, set wins, so no event is lost.
- Counter:
  - contagem[i] increments by 1 on each cycle detector[i]=1 and saturates at 2^CNT_W-1.
  - limpa[i]=1 with no pulse sets it to 0.
  - limpa[i]=1 with a pulse in the same cycle sets it to 1.
- irq <= |pendente; 1 cycle behind pendente.
- Channels are fully independent; no cross-channel priority.

Optional Feature:
DETECTOR_DEBOUNCE_EN
- Defined:
  - A per-channel debounce filter sits between s and the edge compute and holds filtered level f.
  - Counter ctr, width clog2(DEB_CYCLES)+1, resets to 0.
  - If s==f: ctr <= 0.
  - Else if ctr==DEB_CYCLES-1: f <= s and ctr <= 0.
  - Else: ctr <= ctr+1.
  - Edge compute uses f instead of s.
  - Glitches shorter than DEB_CYCLES cycles are ignored.
  - Latency becomes SYNC_STAGES+DEB_CYCLES+1.
  - f resets to 0.
- Undefined: no filter logic is generated; behaviour is as above with zero extra latency.

Decomposition:
- Package detector_borda_pkg holds:
  - mode constants MODO_OFF=2'b00, MODO_SUBIDA=2'b01, MODO_DESCIDA=2'b10, MODO_AMBAS=2'b11
  - mode_t typedef (2 bits)
- Sub-module detector_borda_canal implements one channel: sync, optional debounce, edge, pending, counter.
- The top instantiates N_CH copies via generate and builds irq.

Test Plan:
1. Reset release with entrada=2'b01, SYNC_STAGES=2, modo=01 on both channels -> detector[0] high exactly at cycle 3 after release, for one cycle; detector[1] stays 0; pendente=01; contagem ch0=1; irq=1 one cycle after pendente.
2. Channel 1 mode 10, entrada[1] goes 1 then 0 three cycles later -> one pulse on detector[1] 3 cycles after the falling edge only; no pulse for the rise.
3. Mode 11, entrada toggles every cycle for 6 cycles -> 6 consecutive pulses; contagem=6.
4. limpa[0]=1 in the same cycle detector[0]=1 -> pendente[0] stays 1; contagem[0]=1. limpa[0]=1 alone -> pendente[0]=0 and contagem[0]=0 next cycle; irq drops one cycle later.
5. CNT_W=2, 5 rising edges -> contagem saturates at 3.
6. DETECTOR_DEBOUNCE_EN, DEB_CYCLES=4:
   - 3-cycle high glitch -> no pulse.
   - 4-cycle-stable high -> one pulse at SYNC_STAGES+5 cycles.
   - rst asserted mid-count -> all outputs 0 immediately, with no pulse after release when entrada=0.

Source files
------------

// File: rtl/detector_borda_pkg.sv
// Shared edge-mode encoding and pulse-selection helper for the multi-channel edge detector.
package detector_borda_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODO_OFF     = 2'b00;
  localparam mode_t MODO_SUBIDA  = 2'b01;
  localparam mode_t MODO_DESCIDA = 2'b10;
  localparam mode_t MODO_AMBAS   = 2'b11;

  function automatic logic pulso_sel(input mode_t modo, input logic rise, input logic fall);
    logic p;
    p = 1'b0;
    case (modo)
      MODO_SUBIDA:  p = rise;
      MODO_DESCIDA: p = fall;
      MODO_AMBAS:   p = rise | fall;
      default:      p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/detector_borda_canal.sv
// One detector channel: synchroniser, optional debounce (DETECTOR_DEBOUNCE_EN),
// edge compute, sticky pending flag and saturating event counter.
module detector_borda_canal
  import detector_borda_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entrada,
  input  mode_t            modo,
  input  logic             limpa,
  output logic             detector,
  output logic             pendente,
  output logic [CNT_W-1:0] contagem
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s;
  logic nivel;
  logic prev;
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = entrada;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain <= '0;
        else      chain <= (chain << 1) | SYNC_STAGES'(entrada);
      end
      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

`ifdef DETECTOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  logic          f;
  logic [DW-1:0] ctr;

  // f only follows s once s has disagreed with it for DEB_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f   <= 1'b0;
      ctr <= '0;
    end else if (s == f) begin
      ctr <= '0;
    end else if (ctr == DW'(DEB_CYCLES - 1)) begin
      f   <= s;
      ctr <= '0;
    end else begin
      ctr <= ctr + DW'(1);
    end
  end
  assign nivel = f;
`else
  assign nivel = s;
`endif

  assign rise = nivel & ~prev;
  assign fall = ~nivel & prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= 1'b0;
      detector <= 1'b0;
    end else begin
      prev     <= nivel;
      detector <= pulso_sel(modo, rise, fall);
    end
  end

  // A pulse coinciding with a clear wins, so the event is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendente <= 1'b0;
      contagem <= '0;
    end else if (detector) begin
      pendente <= 1'b1;
      if (limpa)                    contagem <= CNT_W'(1);
      else if (contagem != CNT_MAX) contagem <= contagem + CNT_W'(1);
    end else if (limpa) begin
      pendente <= 1'b0;
      contagem <= '0;
    end
  end

endmodule

// File: rtl/detector_borda_multi.sv
// Multi-channel edge detector top: N_CH independent channels plus a summarising irq.
// Optional debounce filter enabled by defining DETECTOR_DEBOUNCE_EN.
module detector_borda_multi
  import detector_borda_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       entrada,
  input  logic [2*N_CH-1:0]     modo,
  input  logic [N_CH-1:0]       limpa,
  output logic [N_CH-1:0]       detector,
  output logic [N_CH-1:0]       pendente,
  output logic [N_CH*CNT_W-1:0] contagem,
  output logic                  irq
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_canal
      detector_borda_canal #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_canal (
        .clk     (clk),
        .rst     (rst),
        .entrada (entrada[i]),
        .modo    (mode_t'(modo[2*i +: 2])),
        .limpa   (limpa[i]),
        .detector(detector[i]),
        .pendente(pendente[i]),
        .contagem(contagem[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |pendente;
  end

endmodule

// File: tb/tb_detector_borda_multi.sv
// Scoreboard bench for detector_borda_multi: a behavioural model predicts every cycle's outputs.
module tb_detector_borda_multi;

  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int DEB_CYCLES  = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       entrada;
  logic [2*N_CH-1:0]     modo;
  logic [N_CH-1:0]       limpa;
  logic [N_CH-1:0]       detector;
  logic [N_CH-1:0]       pendente;
  logic [N_CH*CNT_W-1:0] contagem;
  logic                  irq;

  always #5 clk = ~clk;

  detector_borda_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .modo(modo), .limpa(limpa),
    .detector(detector), .pendente(pendente), .contagem(contagem), .irq(irq)
  );

  typedef struct packed {
    logic [N_CH-1:0]       det;
    logic [N_CH-1:0]       pend;
    logic [N_CH*CNT_W-1:0] cnt;
    logic                  irq;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int passed = 0;

  // Reference model: each input bit becomes visible SYNC_STAGES cycles later
  logic [N_CH-1:0] dly[$];
  int mPrev[N_CH], mF[N_CH], mRun[N_CH], mDet[N_CH], mPend[N_CH], mCnt[N_CH];
  int mIrq;
  logic prevRst = 1'b1;

  task automatic modelReset();
    dly.delete();
    for (int k = 0; k < SYNC_STAGES; k++) dly.push_back('0);
    for (int i = 0; i < N_CH; i++) begin
      mPrev[i] = 0; mF[i] = 0; mRun[i] = 0; mDet[i] = 0; mPend[i] = 0; mCnt[i] = 0;
    end
    mIrq = 0;
  endtask

  task automatic modelStep(input logic [N_CH-1:0] e, input logic [2*N_CH-1:0] m, input logic [N_CH-1:0] l);
    logic [N_CH-1:0] sNow;
    int anyPend, lvl, nd;
    if (SYNC_STAGES == 0) sNow = e;
    else begin
      sNow = dly.pop_front();
      dly.push_back(e);
    end
    anyPend = 0;
    for (int i = 0; i < N_CH; i++) if (mPend[i] != 0) anyPend = 1;
    for (int i = 0; i < N_CH; i++) begin
`ifdef DETECTOR_DEBOUNCE_EN
      lvl = mF[i];
      if (int'(sNow[i]) != mF[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB_CYCLES) begin
          mF[i] = int'(sNow[i]);
          mRun[i] = 0;
        end
      end else mRun[i] = 0;
`else
      lvl = int'(sNow[i]);
`endif
      nd = ((lvl == 1 && mPrev[i] == 0 && m[2*i]) || (lvl == 0 && mPrev[i] == 1 && m[2*i+1])) ? 1 : 0;
      if (mDet[i] != 0) begin
        mPend[i] = 1;
        mCnt[i] = l[i] ? 1 : ((mCnt[i] + 1 > CNT_MAX) ? CNT_MAX : mCnt[i] + 1);
      end else if (l[i]) begin
        mPend[i] = 0;
        mCnt[i] = 0;
      end
      mPrev[i] = lvl;
      mDet[i] = nd;
    end
    mIrq = anyPend;
  endtask

  function automatic exp_t modelOut();
    exp_t x;
    x = '0;
    for (int i = 0; i < N_CH; i++) begin
      x.det[i] = (mDet[i] != 0);
      x.pend[i] = (mPend[i] != 0);
      x.cnt[i*CNT_W +: CNT_W] = CNT_W'(mCnt[i]);
    end
    x.irq = (mIrq != 0);
    return x;
  endfunction

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic checkOutput(input string tag, input exp_t req);
    checkField({tag, ".detector"}, 64'(detector), 64'(req.det));
    checkField({tag, ".pendente"}, 64'(pendente), 64'(req.pend));
    checkField({tag, ".contagem"}, 64'(contagem), 64'(req.cnt));
    checkField({tag, ".irq"},      64'(irq),      64'(req.irq));
  endtask

  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] e,
                               input logic [2*N_CH-1:0] m, input logic [N_CH-1:0] l);
    @(negedge clk);
    rst = r; entrada = e; modo = m; limpa = l;
    if (!r) modelReset();
    else modelStep(e, m, l);
    expq.push_back(modelOut());
    if (!r && prevRst) begin
      #1;
      checkOutput("async_reset", '0);
    end
    prevRst = r;
  endtask

  task automatic step(input logic [N_CH-1:0] e, input logic [2*N_CH-1:0] m,
                      input logic [N_CH-1:0] l, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, e, m, l);
  endtask

  // Monitor: the DUT presents a result every cycle; compare it with the oldest prediction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput("cycle", expq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_CH-1:0]   e;
    logic [2*N_CH-1:0] m;
    logic [N_CH-1:0]   l;
    rst = 1'b1; entrada = '0; modo = '0; limpa = '0;
    modelReset();
    #2 rst = 1'b0;
    prevRst = 1'b0;

    // Input held high through reset: a single rise event after release
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2'b01, 4'b0101, 2'b00);
    step(2'b01, 4'b0101, 2'b00, 8);

    // Channel 1 in fall mode: only the falling edge pulses
    step(2'b11, 4'b1001, 2'b00, 3);
    step(2'b01, 4'b1001, 2'b00, 6);

    // Both-edge mode with a toggle every cycle
    e = 2'b01;
    for (int k = 0; k < 6; k++) begin
      e[0] = ~e[0];
      step(e, 4'b1111, 2'b00, 1);
    end
    step(e, 4'b1111, 2'b00, 6);

    // Clear while pulses arrive, then a clear on its own
    for (int k = 0; k < 4; k++) begin
      e[0] = ~e[0];
      step(e, 4'b1111, 2'b01, 1);
    end
    step(e, 4'b1111, 2'b00, 5);
    step(e, 4'b1111, 2'b01, 1);
    step(e, 4'b1111, 2'b00, 4);

    // Five rising edges: counter saturates
    step(2'b00, 4'b0101, 2'b11, 1);
    for (int k = 0; k < 5; k++) begin
      step(2'b01, 4'b0101, 2'b00, 1);
      step(2'b00, 4'b0101, 2'b00, 1);
    end
    step(2'b00, 4'b0101, 2'b00, 5);

    // Short glitch and a long stable high on channel 1
    step(2'b10, 4'b0101, 2'b00, 3);
    step(2'b00, 4'b0101, 2'b00, 8);
    step(2'b10, 4'b0101, 2'b00, 6);
    step(2'b10, 4'b0101, 2'b00, 8);

    // Reset asserted mid-count, released with inputs low
    step(2'b01, 4'b0101, 2'b00, 2);
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 2'b00, 4'b0101, 2'b00);
    step(2'b00, 4'b0101, 2'b00, 10);

    // Randomised traffic including mode changes and clears
    e = '0; m = 4'b1111;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(2) == 0) e[i] = ~e[i];
        if ($urandom_range(19) == 0) m[2*i +: 2] = 2'($urandom_range(3));
        l[i] = ($urandom_range(7) == 0);
      end
      step(e, m, l, 1);
    end
    step(e, m, 2'b00, 10);

    @(posedge clk);
    #2;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("[TB] FAIL drain: got %0d pending predictions required 0", expq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
